// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the serial word link (p2s_tx / s2p side).
//   - default parallel word width and length-field width
//   - transmitter state encodings and state enum
package p2s_pkg;

  localparam int P2S_WIDTH = 16;
  localparam int P2S_LEN_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY,
    DONE   = ST_DONE
  } p2s_state_t;

endpackage

// File: rtl/p2s_shift_reg.sv
// p2s_shift_reg: loadable left-shift register plus bit down-counter.
// The register holds the bits still waiting behind the one currently on the
// line, so its MSB tap is the next bit to transmit.
// Ports:
//   clk, reset      : clock (posedge), async active-high reset
//   load            : load load_data / load_count
//   shift           : shift left by one (zero fill) and decrement count
//   load_data       : bits following the first transmitted bit, MSB-aligned
//   load_count      : number of bits in the word
//   next_msb        : MSB tap (next bit to go out)
//   count_one       : count == 1 (last bit currently on the line)
//   count_zero      : count == 0
module p2s_shift_reg #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-2:0] load_data,
  input  logic [LEN_W-1:0] load_count,
  output logic             next_msb,
  output logic             count_one,
  output logic             count_zero
);

  logic [WIDTH-2:0] sreg;
  logic [LEN_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg  <= '0;
      count <= '0;
    end else if (load) begin
      sreg  <= load_data;
      count <= load_count;
    end else if (shift) begin
      sreg  <= {sreg[WIDTH-3:0], 1'b0};
      count <= count - LEN_W'(1);
    end
  end

  assign next_msb   = sreg[WIDTH-2];
  assign count_one  = (count == LEN_W'(1));
  assign count_zero = (count == '0);

endmodule

// File: rtl/p2s_tx.sv
// p2s_tx: parallel-to-serial transmitter, MSB-first, one bit per clk.
// Optional build macro: P2S_TX_PARITY_EN appends an even-parity bit after
// the data bits (sent even when len == 0).
// Ports:
//   clk      : system clock, posedge active
//   reset    : asynchronous, active-high; clears all state
//   start    : transfer request, sampled only in IDLE
//   data_in  : word to send, captured on accepted start
//   len      : number of bits to send, captured on accepted start
//   ser_out  : serial data (registered)
//   ser_en   : high while ser_out carries a valid bit (registered)
//   busy     : high from the cycle after acceptance until back in IDLE
//   done     : one-cycle completion pulse (registered)
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH,
  parameter int LEN_W = P2S_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  p2s_state_t       state;
  logic [WIDTH-1:0] load_word;
  logic             load;
  logic             shift;
  logic             next_msb;
  logic             count_one;
  logic             count_zero;
`ifdef P2S_TX_PARITY_EN
  logic             parity;
`endif

  // Left-align so data_in[len-1] lands at the MSB; bits above len fall off.
  assign load_word = data_in << (WIDTH - int'(len));
  assign load      = (state == IDLE) && start && (len != '0);
  assign shift     = (state == SHIFT);

  // The first bit goes straight to ser_out on the load edge; the sub-module
  // only keeps the bits that follow it.
  p2s_shift_reg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shift_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .load_data  (load_word[WIDTH-2:0]),
    .load_count (len),
    .next_msb   (next_msb),
    .count_one  (count_one),
    .count_zero (count_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ser_out <= 1'b0;
      ser_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef P2S_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state   <= SHIFT;
              ser_out <= load_word[WIDTH-1];
              ser_en  <= 1'b1;
`ifdef P2S_TX_PARITY_EN
              parity  <= ^load_word;
`endif
            end else begin
`ifdef P2S_TX_PARITY_EN
              // Empty word still carries a (zero) parity bit.
              state   <= PARITY;
              ser_out <= 1'b0;
              ser_en  <= 1'b1;
`else
              state   <= DONE;
              done    <= 1'b1;
`endif
            end
          end
        end
        SHIFT: begin
          // count_zero is unreachable here; treated as terminal for safety.
          if (count_one || count_zero) begin
`ifdef P2S_TX_PARITY_EN
            state   <= PARITY;
            ser_out <= parity;
            ser_en  <= 1'b1;
`else
            state   <= DONE;
            ser_out <= 1'b0;
            ser_en  <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            ser_out <= next_msb;
            ser_en  <= 1'b1;
          end
        end
`ifdef P2S_TX_PARITY_EN
        PARITY: begin
          state   <= DONE;
          ser_out <= 1'b0;
          ser_en  <= 1'b0;
          done    <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ser_out <= 1'b0;
          ser_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_tx.sv
// tb_p2s_tx: directed, scoreboard-based bench for p2s_tx.
// Expected serial bits are queued when a word is driven and popped by a
// negedge monitor whenever ser_en is high.
module tb_p2s_tx;

`ifdef P2S_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  len;
  logic        ser_out;
  logic        ser_en;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  bit mon_exp;

  p2s_tx #(.WIDTH(16), .LEN_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .len     (len),
    .ser_out (ser_out),
    .ser_en  (ser_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Serial line monitor: every valid bit must match the next queued bit.
  always @(negedge clk) begin
    if (ser_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_bit: observed=%0b expected=none", ser_out);
      end else begin
        mon_exp = exp_q.pop_front();
        assert (ser_out === mon_exp) else begin
          errors++;
          $error("FAIL ser_bit: observed=%0b expected=%0b", ser_out, mon_exp);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input int n);
    bit p;
    p = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      p ^= d[i];
    end
    if (PAR == 1) exp_q.push_back(p);
  endtask

  // Sends one word from IDLE and checks the full handshake timing.
  task automatic send(input logic [15:0] d, input int n, input string tag);
    push_word(d, n);
    start   = 1'b1;
    data_in = d;
    len     = 4'(n);
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = 16'hFFFF;
    len     = 4'd15;
    for (int k = 0; k < n + PAR; k++) begin
      step();
      check({tag, "_en"},   32'(ser_en), 32'd1);
      check({tag, "_busy"}, 32'(busy),   32'd1);
      check({tag, "_done"}, 32'(done),   32'd0);
    end
    step();
    check({tag, "_donepulse"}, 32'(done),    32'd1);
    check({tag, "_en_off"},    32'(ser_en),  32'd0);
    check({tag, "_out_off"},   32'(ser_out), 32'd0);
    check({tag, "_busy_done"}, 32'(busy),    32'd1);
    step();
    check({tag, "_done_clr"},  32'(done),    32'd0);
    check({tag, "_busy_clr"},  32'(busy),    32'd0);
    check({tag, "_idle_en"},   32'(ser_en),  32'd0);
    check({tag, "_q_empty"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    len     = '0;
    step();
    step();
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_ser_en",  32'(ser_en),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    reset = 1'b0;
    step();

    // Basic word: 0x00A5, 8 bits -> 1,0,1,0,0,1,0,1
    send(16'h00A5, 8, "a5");
    // Empty word: done the next cycle, no data bits
    send(16'h1234, 0, "len0");
    // Upper bits beyond len are not sent
    send(16'hF00D, 4, "trunc");
    // Maximum length
    send(16'h5A3C, 15, "max");
    send(16'h0007, 3, "seven");

    // Asynchronous reset during bit 3 of a 12-bit word
    push_word(16'h0ABC, 12);
    start   = 1'b1;
    data_in = 16'h0ABC;
    len     = 4'd12;
    @(posedge clk);
    #1;
    start = 1'b0;
    step();
    step();
    step();
    check("mid_en_before", 32'(ser_en),  32'd1);
    check("mid_out_before", 32'(ser_out), 32'd1);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("async_ser_out", 32'(ser_out), 32'd0);
    check("async_ser_en",  32'(ser_en),  32'd0);
    check("async_busy",    32'(busy),    32'd0);
    check("async_done",    32'(done),    32'd0);
    step();
    reset = 1'b0;
    step();
    check("no_resume_en",   32'(ser_en), 32'd0);
    check("no_resume_busy", 32'(busy),   32'd0);
    send(16'h0FFF, 12, "ones");

    // Back-to-back with start held: SHIFT x(2+PAR), DONE, IDLE, repeat.
    // The ser_en gap is the DONE cycle plus the IDLE re-sample cycle.
    push_word(16'h0003, 2);
    push_word(16'h0003, 2);
    push_word(16'h0003, 2);
    start   = 1'b1;
    data_in = 16'h0003;
    len     = 4'd2;
    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 2 + PAR; k++) begin
        step();
        check("b2b_en", 32'(ser_en), 32'd1);
        if (w == 0 && k == 0) data_in = 16'h0000;
      end
      step();
      check("b2b_gap_en", 32'(ser_en), 32'd0);
      check("b2b_done",   32'(done),   32'd1);
      data_in = 16'h0003;
      if (w == 2) start = 1'b0;
      step();
      check("b2b_idle_en",   32'(ser_en), 32'd0);
      check("b2b_idle_busy", 32'(busy),   32'd0);
      check("b2b_idle_done", 32'(done),   32'd0);
    end
    step();
    check("b2b_stop_en",  32'(ser_en), 32'd0);
    check("b2b_q_empty",  32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
